// File: rtl/serial_rx_deframer_pkg.sv
// Shared serial line definitions: parity modes, receiver FSM states and
// the baud divider rule used by both the receiver and the transmitter.
package serial_rx_deframer_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/serial_rx_deframer_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks,
// restartable so the sample grid can lock onto a start edge.
module serial_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_rx_deframer.sv
// UART receive deframer: oversampled start/data/parity/stop recovery
// with a valid/ready byte output and cts flow control.
module serial_rx_deframer
  import serial_rx_deframer_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = PARITY_EVEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       cts
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic          ODD_P = (PARITY == PARITY_ODD);

  state_t        state;
  logic          rx_m;
  logic          rxs;
  logic [SW-1:0] samp;
  logic [2:0]    bitcnt;
  logic [7:0]    sh;
  logic          s_lo;
  logic          s_mid;
  logic          perr;
  logic          tick;
  logic          restart;
  logic          maj;
  logic          decide;
  logic          bit_end;

  assign restart = (state == ST_IDLE) && !rxs;
  assign decide  = tick && (samp == S_HI);
  assign bit_end = tick && (samp == S_END);
  assign maj     = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);

  serial_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rxs        <= 1'b1;
      state      <= ST_IDLE;
      samp       <= '0;
      bitcnt     <= '0;
      sh         <= '0;
      s_lo       <= 1'b1;
      s_mid      <= 1'b1;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      cts        <= 1'b0;
    end else begin
      rx_m    <= rx;
      rxs     <= rx_m;
      overrun <= 1'b0;
      cts     <= ~data_valid;
      if (data_valid && data_ready)
        data_valid <= 1'b0;
      if (state == ST_IDLE)
        samp <= '0;
      else if (tick)
        samp <= samp + 1'b1;
      if (tick && samp == S_LO)
        s_lo <= rxs;
      if (tick && samp == S_MID)
        s_mid <= rxs;
      case (state)
        ST_IDLE: begin
          if (!rxs)
            state <= ST_START;
        end
        ST_START: begin
          if (decide && maj) begin
            state <= ST_IDLE;
          end else if (bit_end) begin
            state  <= ST_DATA;
            bitcnt <= '0;
          end
        end
        ST_DATA: begin
          if (decide)
            sh <= {maj, sh[7:1]};
          if (bit_end) begin
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7)
              state <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (decide)
            perr <= (^sh) ^ maj ^ ODD_P;
          if (bit_end)
            state <= ST_STOP;
        end
        // Leave mid-stop-bit so the next start edge is never missed.
        ST_STOP: begin
          if (decide) begin
            if (!maj && sh == 8'h00 && !rxs)
              state <= ST_BREAK;
            else
              state <= ST_IDLE;
            if (!data_valid || data_ready) begin
              data_out   <= sh;
              parity_err <= perr;
              frame_err  <= ~maj;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (rxs)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_rx_deframer.md
Name: serial_rx_deframer

Overview:
UART receive deframer feeding the serial echo datapath. It oversamples the asynchronous rx line and recovers 8-bit characters. It checks parity and the stop bit, then presents each byte on a valid/ready handshake to the echo/increment stage. It drives cts so the remote side is throttled while an undelivered byte is held.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, samples per bit period (must be a power of 2, at least 8)
PARITY, 2, parity mode: 0 none, 1 odd, 2 even

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx  input  1  asynchronous serial line, idle high
data_out  output  8  received byte, stable while data_valid=1
data_valid  output  1  byte available; held high until accepted
data_ready  input  1  consumer accepts the byte when data_valid & data_ready
parity_err  output  1  parity mismatch for the current data_out, qualified by data_valid
frame_err  output  1  stop bit sampled low for the current data_out, qualified by data_valid
overrun  output  1  one-cycle pulse: a byte completed while data_valid was still high
cts  output  1  clear-to-send to the remote side, high when no byte is pending

Behaviour:
- Reset: synchronous, active-high, affects all state. The cycle after rst is sampled high:
  - outputs: data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, cts=0.
  - FSM goes to IDLE; divider and sample counters are cleared.
  - Reset mid-frame abandons the frame; no byte is delivered.
- cts: registered; cts = ~data_valid, evaluated one cycle after the update; held 0 during reset.
- Input: rx passes through a 2-FF synchronizer (reset value 1); all logic uses the synchronized value rxs.
- Tick: divider DIV = round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)), 27 at the defaults.
  - Produces a one-cycle tick every DIV clocks.
  - The divider restarts from 0 on the IDLE->START transition to align with the start edge.
- Sample counter: 4 bits (log2 OVERSAMPLE), advances on each tick, wraps at OVERSAMPLE-1 to 0; each wrap ends one bit period.
- Bit decision: majority of rxs at sample indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (7, 8, 9 at the default). The decision is taken at sample index OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: rxs==0 -> START.
  - START: majority==1 -> IDLE (glitch rejected, nothing reported); else -> DATA at the end of the bit period.
  - DATA: 8 bits, LSB first, into a shift register; bit counter 0..7. After bit 7 -> PARITY if PARITY!=0, else STOP.
  - PARITY: even mode requires XOR(data, p)==0; odd mode requires it ==1. The result is latched as perr.
  - STOP: decided at sample 9, and the FSM leaves immediately (half-bit early, for resync).
    - Stop majority==1 -> IDLE.
    - Stop majority==0 -> ferr=1; if the data byte was 0x00 and rxs is still 0 -> BREAK_WAIT, else IDLE.
  - BREAK_WAIT: waits for rxs==1, then -> IDLE.
- Delivery: on the STOP decision, and if data_valid==0:
  - the next cycle data_out=shift register, parity_err=perr, frame_err=ferr, data_valid=1.
  - Latency from the stop-bit sample 9 tick to data_valid is 1 clock.
- Handshake: data_valid is deasserted the cycle after data_valid & data_ready.
  - data_out and the error flags hold their values until a new byte loads.
- Simultaneous acceptance: data_ready=1 in the same cycle a new byte completes. The acceptance wins, the new byte loads, data_valid stays 1, and there is no overrun.
- Overrun: a byte completes while data_valid=1 and data_ready=0.
  - The new byte is dropped and the held byte is kept.
  - overrun pulses high for exactly 1 cycle.
- Error flags: never sticky beyond the byte they describe.

Decomposition:
- Shared package/header serial_defs holds:
  - PARITY_NONE/ODD/EVEN constants;
  - FSM state encodings (3-bit);
  - the DIV computation macro/function, so the matching transmitter uses identical timing.
- One sub-module, serial_baud_tick: parameterized divider with sync restart input and one-cycle tick output. It is reused by the transmitter (transmitter uses OVERSAMPLE=1).

Test Plan:
- Single frame, 8E1, byte 0x41 (parity bit 0), data_ready=1 -> data_valid 1 cycle, data_out=0x41, parity_err=0, frame_err=0, cts dips to 0 for 1 cycle.
- Byte 0x41 sent with parity bit 1 -> data_out=0x41, parity_err=1, frame_err=0; next correct frame 0x7E -> parity_err=0.
- Byte 0x55 with stop bit 0, then line high -> data_out=0x55, frame_err=1. Then 20 bit-times of all-zero (break) -> one byte 0x00 with frame_err=1, no further bytes until rx returns high.
- rx low pulse of 4 sample periods (4*27 clocks) -> no data_valid; a following valid frame 0xA5 is received correctly.
- Frames 0x10 then 0x11 back-to-back, data_ready=0 -> data_out stays 0x10, overrun pulses once, cts=0. After data_ready=1 -> data_valid drops, cts=1.
- rst asserted mid-way through data bit 4 of a frame -> all outputs 0 next cycle, no byte delivered. The next frame 0xC3 is received correctly.
- Stream 0x00..0xFF back-to-back, data_ready=1, clock ±2% baud skew -> all 256 bytes in order, no errors.
